// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a transmit queue, STATUS and DIV registers.
// Define UART_FIFO_EN for a FIFO_DEPTH-entry queue; otherwise the queue is one holding register.
module uart_tx_mmio #(
    parameter logic [31:0] BASE       = 32'h1000_0000,
    parameter logic [15:0] DIV_RESET  = 16'd433,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        re,
    input  logic        we,
    input  logic [3:0]  wstrb,
    output logic [31:0] rdata,
    output logic        tx
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state_q, state_d;
    logic [31:0] off;
    logic        hit, sel_tx, sel_st, sel_div;
    logic        push, push_ok, pop;
    logic        full, empty, busy;
    logic [3:0]  count_4;
    logic [7:0]  head;
    logic        ovf_q;
    logic [15:0] div_q;
    logic [15:0] baud_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shreg_q;
    logic        bit_end;
    logic        tx_d, tx_q;
    logic [31:0] rd_val;
    logic        unused_bits;

    // Offset-based decode so an unaligned BASE still maps exactly 12 bytes
    assign off     = addr - BASE;
    assign hit     = (off < 32'd12);
    assign sel_tx  = hit && (off[3:2] == 2'd0);
    assign sel_st  = hit && (off[3:2] == 2'd1);
    assign sel_div = hit && (off[3:2] == 2'd2);

    assign push    = we && sel_tx && wstrb[0];
    assign push_ok = push && (!full || pop);
    assign busy    = (state_q != IDLE);

`ifdef UART_FIFO_EN
    localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

    logic [7:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;

    assign full    = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign count_4 = 4'(count_q);
    assign head    = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= wdata[7:0];
    end

    assign unused_bits = &{1'b0, wdata[31:16]};
`else
    logic [7:0] hold_q;
    logic       hold_vld_q;

    assign full    = hold_vld_q;
    assign empty   = !hold_vld_q;
    assign count_4 = {3'd0, hold_vld_q};
    assign head    = hold_q;

    // A push alongside a pop refills the register, so valid stays set
    always_ff @(posedge clk) begin
        if (rst)          hold_vld_q <= 1'b0;
        else if (push_ok) hold_vld_q <= 1'b1;
        else if (pop)     hold_vld_q <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push_ok) hold_q <= wdata[7:0];
    end

    localparam int DEPTH_IGN = FIFO_DEPTH;
    assign unused_bits = &{1'b0, wdata[31:16], DEPTH_IGN[0]};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            div_q <= DIV_RESET;
        end else begin
            if (push && full && !pop)
                ovf_q <= 1'b1;
            else if (we && sel_st && wstrb[0] && wdata[3])
                ovf_q <= 1'b0;
            if (we && sel_div) begin
                if (wstrb[0]) div_q[7:0]  <= wdata[7:0];
                if (wstrb[1]) div_q[15:8] <= wdata[15:8];
            end
        end
    end

    assign bit_end = (baud_q == 16'd0);

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: if (bit_end) state_d = DATA;
            DATA:  if (bit_end && (bit_idx_q == 3'd7)) state_d = STOP;
            STOP:  if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_q[0];
            default: tx_d = 1'b1;
        endcase
    end

    // Baud counter reloads from DIV at every boundary, so a new DIV lands on the next bit
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tx_q      <= 1'b1;
            baud_q    <= 16'd0;
            bit_idx_q <= 3'd0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            if (pop) begin
                baud_q    <= div_q;
                bit_idx_q <= 3'd0;
            end else if (state_q != IDLE) begin
                if (bit_end) begin
                    baud_q <= div_q;
                    if (state_q == DATA) bit_idx_q <= bit_idx_q + 3'd1;
                end else begin
                    baud_q <= baud_q - 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pop)
            shreg_q <= head;
        else if ((state_q == DATA) && bit_end)
            shreg_q <= {1'b0, shreg_q[7:1]};
    end

    always_comb begin
        rd_val = 32'd0;
        if (sel_st)
            rd_val = {20'd0, count_4, 4'd0, ovf_q, empty, full, busy};
        else if (sel_div)
            rd_val = {16'd0, div_q};
    end

    // Read data is captured before any same-cycle write lands
    always_ff @(posedge clk) begin
        if (rst)     rdata <= 32'd0;
        else if (re) rdata <= rd_val;
    end

    assign tx = tx_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed self-checking bench for uart_tx_mmio: register access, frame timing, overflow, reset abort.
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE = 32'h1000_0000;
`ifdef UART_FIFO_EN
    localparam logic [31:0] ST_OVF     = 32'h0000_080B;
    localparam logic [31:0] ST_OVF_CLR = 32'h0000_0803;
`else
    localparam logic [31:0] ST_OVF     = 32'h0000_010B;
    localparam logic [31:0] ST_OVF_CLR = 32'h0000_0103;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  wstrb = 4'd0;
    logic [31:0] rdata;
    logic        tx;

    int n_chk  = 0;
    int n_pass = 0;

    uart_tx_mmio #(.BASE(BASE), .DIV_RESET(16'd433), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .re(re), .we(we),
        .wstrb(wstrb), .rdata(rdata), .tx(tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        addr = a; wdata = d; wstrb = s; we = 1'b1;
        @(negedge clk);
        we = 1'b0; wstrb = 4'd0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a; re = 1'b1;
        @(negedge clk);
        re = 1'b0;
        d = rdata;
    endtask

    // seq is LSB first; each bit is expected on tx for rep consecutive clocks
    task automatic watch_tx(input string tag, input logic [63:0] seq, input int n, input int rep);
        for (int i = 0; i < n; i++) begin
            for (int r = 0; r < rep; r++) begin
                @(negedge clk);
                chk(tag, {31'd0, tx}, {31'd0, seq[i]});
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    logic [31:0] rd;
    int lows;

    initial begin
        // Reset state
        @(negedge clk);
        chk("tx_in_reset", {31'd0, tx}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        chk("rdata_reset", rdata, 32'd0);
        chk("tx_after_reset", {31'd0, tx}, 32'd1);
        bus_read(BASE + 32'h4, rd); chk("status_reset", rd, 32'h0000_0004);
        bus_read(BASE + 32'h8, rd); chk("div_reset", rd, 32'd433);
        chk("tx_idle", {31'd0, tx}, 32'd1);

        // Single byte 0xA5 at DIV=3
        bus_write(BASE + 32'h8, 32'd3, 4'b0011);
        bus_write(BASE + 32'h0, 32'hA5, 4'b0001);
        chk("a5_pre0", {31'd0, tx}, 32'd1);
        @(negedge clk);
        chk("a5_pre1", {31'd0, tx}, 32'd1);
        watch_tx("a5_frame", {54'd0, 1'b1, 8'hA5, 1'b0}, 10, 4);
        bus_read(BASE + 32'h4, rd); chk("a5_status_done", rd, 32'h0000_0004);

        // Back-to-back 0x55, 0x0F at DIV=0
        bus_write(BASE + 32'h8, 32'd0, 4'b0011);
        @(negedge clk);
        addr = BASE; wdata = 32'h55; wstrb = 4'b0001; we = 1'b1;
        @(negedge clk);
        wdata = 32'h0F;
        @(negedge clk);
        we = 1'b0; wstrb = 4'd0;
        chk("b2b_pre", {31'd0, tx}, 32'd1);
        watch_tx("b2b_frames", {43'd0, 1'b1, 8'h0F, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0}, 21, 1);
        bus_read(BASE + 32'h4, rd); chk("b2b_status_done", rd, 32'h0000_0004);

        // Overflow: ten writes back-to-back at DIV=100
        bus_write(BASE + 32'h8, 32'd100, 4'b0011);
        @(negedge clk);
        addr = BASE; wstrb = 4'b0001; we = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wdata = 32'h30 + i;
            @(negedge clk);
        end
        we = 1'b0; wstrb = 4'd0;
        bus_read(BASE + 32'h4, rd); chk("ovf_status", rd, ST_OVF);
        bus_write(BASE + 32'h4, 32'h8, 4'b0001);
        bus_read(BASE + 32'h4, rd); chk("ovf_cleared", rd, ST_OVF_CLR);

        // Reset mid-frame
        pulse_reset();
        bus_read(BASE + 32'h4, rd); chk("flush_status", rd, 32'h0000_0004);
        bus_write(BASE + 32'h8, 32'd9, 4'b0011);
        bus_write(BASE + 32'h0, 32'h00, 4'b0001);
        repeat (15) @(negedge clk);
        chk("mid_data_tx", {31'd0, tx}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_tx", {31'd0, tx}, 32'd1);
        bus_read(BASE + 32'h4, rd); chk("abort_status", rd, 32'h0000_0004);
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        chk("abort_no_frame", lows, 0);
        bus_read(BASE + 32'h8, rd); chk("abort_div", rd, 32'd433);

        // Decode and byte enables
        bus_read(BASE + 32'hC, rd); chk("read_unmapped", rd, 32'd0);
        bus_read(BASE + 32'h0, rd); chk("read_txdata", rd, 32'd0);
        bus_write(BASE + 32'h8, 32'h1234_5678, 4'b0001);
        bus_read(BASE + 32'h8, rd); chk("div_low_byte", rd, 32'h0000_0178);
        bus_write(BASE + 32'hC, 32'hFFFF_FFFF, 4'b1111);
        bus_write(BASE + 32'h18, 32'hFFFF_FFFF, 4'b1111);
        bus_read(BASE + 32'h8, rd); chk("div_after_unmapped_wr", rd, 32'h0000_0178);
        bus_read(BASE + 32'h4, rd); chk("status_after_unmapped_wr", rd, 32'h0000_0004);
        @(negedge clk);
        addr = BASE + 32'h8; wdata = 32'h0000_0055; wstrb = 4'b0011; we = 1'b1; re = 1'b1;
        @(negedge clk);
        we = 1'b0; re = 1'b0; wstrb = 4'd0;
        chk("rw_pre_value", rdata, 32'h0000_0178);
        bus_read(BASE + 32'h8, rd); chk("rw_post_value", rd, 32'h0000_0055);
        repeat (3) @(negedge clk);
        chk("rdata_hold", rdata, 32'h0000_0055);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the core's data bus, beside the RAM bus and using the same bus signals. The core writes bytes into a transmit queue. The block serialises them as 8N1 frames on a single output pin at a programmable bit period. Status and divider registers are readable, so firmware can poll before writing.

## Interface
Parameters:
- BASE, 32'h1000_0000: byte address of register 0; the block responds only to BASE..BASE+0xB.
- DIV_RESET, 16'd433: reset value of the DIV register (bit period = DIV+1 clocks).
- FIFO_DEPTH, 8: queue depth when UART_FIFO_EN is defined; power of two, ≥2.

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- addr  in  32  bus byte address; decoded on addr[3:2] after the BASE match; addr[1:0] ignored.
- wdata  in  32  write data.
- re  in  1  read strobe, one cycle per access.
- we  in  1  write strobe, one cycle per access.
- wstrb  in  4  byte enables for writes.
- rdata  out  32  read data, registered.
- tx  out  1  serial output, idle high.

## Operation
Register map (offset from BASE):
- 0x0 TXDATA (write only; reads return 0).
  - A write with wstrb[0]=1 pushes wdata[7:0] into the queue.
  - If the queue is full, the byte is dropped and OVF is set.
- 0x4 STATUS (read).
  - bit0 BUSY: frame in progress.
  - bit1 FULL.
  - bit2 EMPTY.
  - bit3 OVF: sticky; cleared by writing 1 to bit3 with wstrb[0].
  - bits[11:8] COUNT: queued entries.
  - Other bits 0.
- 0x8 DIV (RW, bits[15:0]).
  - Written bytes follow wstrb[1:0]; upper bytes ignored and read as 0.
  - A new value takes effect at the next bit boundary.

Bus rules:
- Addresses outside the map read 0 and ignore writes.
- re and we together: the write completes, and the read returns the pre-write value.

Transmit FSM states IDLE, START, DATA, STOP:
- IDLE: tx=1.
  - If the queue is non-empty, pop the head into a shift register, load the bit counter, go to START.
- START: tx=0 for DIV+1 clocks.
- DATA: 8 bits, LSB first, each held DIV+1 clocks.
- STOP: tx=1 for DIV+1 clocks.
  - Then go to IDLE. A queued byte starts the next START on the following cycle, so there is 1 idle clock between back-to-back frames.

Counters:
- The baud counter is 16 bits and counts down from DIV to 0. A bit boundary occurs when the counter is 0.
- The bit index is 3 bits.

BUSY definition: 1 in every state except IDLE.

Simultaneous push and pop:
- A push and a pop in the same cycle on a full queue succeeds with no overflow.
- Count is unchanged when push and pop coincide.
- Pointers wrap modulo depth.

## Timing
- Reset values: rdata=0, tx=1, state IDLE, queue empty (EMPTY=1, COUNT=0), OVF=0, DIV=DIV_RESET.
- Read latency 1: rdata is valid the cycle after re. rdata holds its value until the next re.
- Write latency: register or queue state updates at the clock edge where we=1.
- A pushed byte reaches tx as the START bit 2 clocks after the write edge: one cycle to see non-empty, one to pop.
- Frame length: 10×(DIV+1) clocks.
- A reset mid-frame aborts the frame: tx=1 immediately after the reset edge, and the queue is flushed.

## Configuration
- UART_FIFO_EN defined: the queue is a FIFO_DEPTH-entry circular buffer; COUNT ranges 0..FIFO_DEPTH.
- UART_FIFO_EN undefined: the queue is a single holding register (depth 1); FULL = !EMPTY; COUNT is 0 or 1; FIFO_DEPTH is ignored.
- Register map, FSM and timing are otherwise identical.

## Test plan
- Reset: assert rst 2 cycles, then read STATUS → 0x0000_0004; read DIV → 433; tx=1 throughout.
- Single byte: write DIV=3, write TXDATA=0xA5 → tx is 0 for 4 clocks, then bits 1,0,1,0,0,1,0,1 at 4 clocks each, then 1 for 4 clocks. START begins 2 clocks after the write. BUSY=1 for 40 clocks.
- Back-to-back: DIV=0, write 0x55 and 0x0F in consecutive cycles → two 10-clock frames separated by exactly 1 idle clock; EMPTY=1 afterwards.
- Overflow (UART_FIFO_EN, depth 8): DIV=100, write 10 bytes back-to-back → first byte popped, 8 queued, 1 dropped. STATUS reads FULL=1, OVF=1, COUNT=8. Write STATUS=0x8 → OVF=0.
- Reset mid-frame: DIV=9, write 0x00, assert rst during DATA → tx=1 next cycle; STATUS=0x4 after reset; no further frame.
- Decode: read BASE+0xC → 0. Write BASE+0x8 with wstrb=4'b0001, wdata=0x1234_5678 → DIV low byte becomes 0x78, high byte unchanged.
